wb_arbiter: RTL and testbench

- Round-robin arbiter that shares one Wishbone B4 pipelined slave bus between NUM_MASTERS masters, e.g. the JTAG debug host and a soft CPU.
- Grants the bus for a whole cycle, from the master's cyc assertion until it drops, and tracks outstanding pipelined requests.
- Forwards acks to the granted master and raises a bus error on an ack timeout.
- Sits between the masters and the system interconnect/slave mux.

---
 rtl/wb_arb_pkg.sv | 27 ++
 rtl/rr_pick.sv | 25 ++
 rtl/wb_arbiter.sv | 155 +++++++++++++++
 tb/tb_wb_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the Wishbone round-robin arbiter.
package wb_arb_pkg;

    typedef enum logic {StIdle, StGrant} arb_state_e;

    localparam int unsigned MaxMasters = 8;

    // First set bit of req searching upward from last+1, wrapping modulo n.
    function automatic logic [2:0] rr_next_idx(input logic [MaxMasters-1:0] req,
                                               input logic [2:0] last,
                                               input int unsigned n);
        logic [2:0]  idx;
        logic        found;
        int unsigned cand;
        idx   = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= MaxMasters; k++) begin
            cand = (32'(last) + k) % n;
            if (k <= n && !found && req[cand[2:0]]) begin
                idx   = cand[2:0];
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: the request after last_i wins.
module rr_pick #(
    parameter int unsigned NUM_REQ = 2,
    localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_i,
    output logic [NUM_REQ-1:0] onehot_o,
    output logic [IDX_W-1:0]   idx_o
);
    import wb_arb_pkg::*;

    logic [MaxMasters-1:0] req_ext;
    logic [2:0]            pick;

    always_comb begin
        req_ext                = '0;
        req_ext[NUM_REQ-1:0]   = req_i;
        pick                   = rr_next_idx(req_ext, 3'(last_i), NUM_REQ);
        idx_o                  = IDX_W'(pick);
        onehot_o               = '0;
        if (|req_i) onehot_o[idx_o] = 1'b1;
    end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin arbiter sharing one pipelined Wishbone B4 slave between several masters,
// with outstanding-request tracking and an ack timeout.
module wb_arbiter #(
    parameter int unsigned NUM_MASTERS     = 2,
    parameter int unsigned ADDR_WIDTH      = 16,
    parameter int unsigned DATA_WIDTH      = 16,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned TIMEOUT         = 1023
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_MASTERS-1:0]            m_cyc_i,
    input  logic [NUM_MASTERS-1:0]            m_stb_i,
    input  logic [NUM_MASTERS-1:0]            m_we_i,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i,
    output logic [DATA_WIDTH-1:0]             m_dat_o,
    output logic [NUM_MASTERS-1:0]            m_ack_o,
    output logic [NUM_MASTERS-1:0]            m_err_o,
    output logic [NUM_MASTERS-1:0]            m_stall_o,
    output logic                              s_cyc_o,
    output logic                              s_stb_o,
    output logic                              s_we_o,
    output logic [ADDR_WIDTH-1:0]             s_adr_o,
    output logic [DATA_WIDTH-1:0]             s_dat_o,
    input  logic [DATA_WIDTH-1:0]             s_dat_i,
    input  logic                              s_ack_i,
    input  logic                              s_stall_i,
    output logic [NUM_MASTERS-1:0]            gnt_o,
    output logic                              busy_o
);
    import wb_arb_pkg::*;

    localparam int unsigned IW         = $clog2(NUM_MASTERS);
    localparam int unsigned OW         = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned TW         = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit          TimeoutEn  = (TIMEOUT != 0);

    arb_state_e             state_q, state_d;
    logic [IW-1:0]          gnt_idx_q, gnt_idx_d;
    logic [NUM_MASTERS-1:0] gnt_oh_q, gnt_oh_d;
    logic [IW-1:0]          last_q, last_d;
    logic [OW-1:0]          outst_q, outst_d;
    logic [TW-1:0]          timer_q, timer_d;

    logic [NUM_MASTERS-1:0] pick_oh;
    logic [IW-1:0]          pick_idx;

    logic [ADDR_WIDTH-1:0]  adr_arr [NUM_MASTERS];
    logic [DATA_WIDTH-1:0]  dat_arr [NUM_MASTERS];

    logic full, timeout, ack_fwd, accept, cur_cyc;

    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_unpack
        assign adr_arr[i] = m_adr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign dat_arr[i] = m_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_pick #(
        .NUM_REQ (NUM_MASTERS)
    ) u_rr_pick (
        .req_i    (m_cyc_i),
        .last_i   (last_q),
        .onehot_o (pick_oh),
        .idx_o    (pick_idx)
    );

    assign m_dat_o = s_dat_i;

    always_comb begin
        state_d   = state_q;
        gnt_idx_d = gnt_idx_q;
        gnt_oh_d  = gnt_oh_q;
        last_d    = last_q;
        outst_d   = outst_q;
        timer_d   = timer_q;

        m_ack_o   = '0;
        m_err_o   = '0;
        m_stall_o = '1;
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        s_we_o    = m_we_i[gnt_idx_q];
        s_adr_o   = adr_arr[gnt_idx_q];
        s_dat_o   = dat_arr[gnt_idx_q];
        gnt_o     = '0;
        busy_o    = 1'b0;

        full      = (outst_q == OW'(MAX_OUTSTANDING));
        timeout   = TimeoutEn && (timer_q == TW'(TIMEOUT));
        cur_cyc   = m_cyc_i[gnt_idx_q];
        ack_fwd   = 1'b0;
        accept    = 1'b0;

        unique case (state_q)
            StIdle: begin
                outst_d = '0;
                timer_d = '0;
                if (|m_cyc_i) begin
                    gnt_idx_d = pick_idx;
                    gnt_oh_d  = pick_oh;
                    state_d   = StGrant;
                end
            end
            StGrant: begin
                busy_o                = 1'b1;
                gnt_o                 = gnt_oh_q;
                // A timing-out cycle also withdraws the strobe so nothing new is issued.
                s_cyc_o               = cur_cyc & ~timeout;
                s_stb_o               = m_stb_i[gnt_idx_q] & ~full & ~timeout;
                m_stall_o[gnt_idx_q]  = s_stall_i | full;
                ack_fwd               = s_ack_i & (outst_q != '0);
                m_ack_o[gnt_idx_q]    = ack_fwd;
                accept                = s_stb_o & ~s_stall_i;

                unique case ({accept, ack_fwd})
                    2'b10:   outst_d = outst_q + 1'b1;
                    2'b01:   outst_d = outst_q - 1'b1;
                    default: outst_d = outst_q;
                endcase

                if (TimeoutEn && outst_q != '0 && !ack_fwd) timer_d = timer_q + 1'b1;
                else                                         timer_d = '0;

                if (timeout || !cur_cyc) begin
                    m_err_o[gnt_idx_q] = timeout;
                    outst_d            = '0;
                    timer_d            = '0;
                    last_d             = gnt_idx_q;
                    state_d            = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            gnt_idx_q <= '0;
            gnt_oh_q  <= '0;
            last_q    <= IW'(NUM_MASTERS - 1);
            outst_q   <= '0;
            timer_q   <= '0;
        end else begin
            state_q   <= state_d;
            gnt_idx_q <= gnt_idx_d;
            gnt_oh_q  <= gnt_oh_d;
            last_q    <= last_d;
            outst_q   <= outst_d;
            timer_q   <= timer_d;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios with literal expectations plus
// random traffic, all checked every cycle against a behavioural model.
module tb_wb_arbiter;

    localparam int NM   = 3;
    localparam int AW   = 16;
    localparam int DW   = 16;
    localparam int MAXO = 4;
    localparam int TO   = 15;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NM-1:0]    m_cyc_i, m_stb_i, m_we_i;
    logic [NM*AW-1:0] m_adr_i;
    logic [NM*DW-1:0] m_dat_i;
    logic [DW-1:0]    m_dat_o;
    logic [NM-1:0]    m_ack_o, m_err_o, m_stall_o, gnt_o;
    logic             s_cyc_o, s_stb_o, s_we_o, busy_o;
    logic [AW-1:0]    s_adr_o;
    logic [DW-1:0]    s_dat_o, s_dat_i;
    logic             s_ack_i, s_stall_i;

    int errors = 0;
    int checks = 0;

    wb_arbiter #(
        .NUM_MASTERS     (NM),
        .ADDR_WIDTH      (AW),
        .DATA_WIDTH      (DW),
        .MAX_OUTSTANDING (MAXO),
        .TIMEOUT         (TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m_cyc_i   (m_cyc_i),
        .m_stb_i   (m_stb_i),
        .m_we_i    (m_we_i),
        .m_adr_i   (m_adr_i),
        .m_dat_i   (m_dat_i),
        .m_dat_o   (m_dat_o),
        .m_ack_o   (m_ack_o),
        .m_err_o   (m_err_o),
        .m_stall_o (m_stall_o),
        .s_cyc_o   (s_cyc_o),
        .s_stb_o   (s_stb_o),
        .s_we_o    (s_we_o),
        .s_adr_o   (s_adr_o),
        .s_dat_o   (s_dat_o),
        .s_dat_i   (s_dat_i),
        .s_ack_i   (s_ack_i),
        .s_stall_i (s_stall_i),
        .gnt_o     (gnt_o),
        .busy_o    (busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: owner is the granted master index or -1 when the bus is free.
    int owner, last, outst, waited;
    bit mvalid = 1'b0;

    initial begin
        logic [NM-1:0] e_ack, e_err, e_stall, e_gnt, cyc_s;
        logic          e_scyc, e_sstb, ackf, acc, drop, full, to;
        int            g;
        forever begin
            @(negedge clk);
            #2;
            ackf = 0; acc = 0; drop = 0;
            cyc_s = m_cyc_i;
            if (mvalid) begin
                e_ack = '0; e_err = '0; e_stall = '1; e_gnt = '0;
                e_scyc = 0; e_sstb = 0;
                if (owner >= 0) begin
                    g          = owner;
                    full       = (outst == MAXO);
                    to         = (TO != 0) && (waited == TO);
                    e_scyc     = m_cyc_i[g] && !to;
                    e_sstb     = m_stb_i[g] && !full && !to;
                    e_stall[g] = s_stall_i || full;
                    ackf       = s_ack_i && (outst > 0);
                    e_ack[g]   = ackf;
                    e_err[g]   = to;
                    e_gnt[g]   = 1'b1;
                    acc        = e_sstb && !s_stall_i;
                    drop       = to || !m_cyc_i[g];
                end
                chk("gnt", 32'(gnt_o), 32'(e_gnt));
                chk("busy", 32'(busy_o), 32'(owner >= 0));
                chk("s_cyc", 32'(s_cyc_o), 32'(e_scyc));
                chk("s_stb", 32'(s_stb_o), 32'(e_sstb));
                chk("m_ack", 32'(m_ack_o), 32'(e_ack));
                chk("m_err", 32'(m_err_o), 32'(e_err));
                chk("m_stall", 32'(m_stall_o), 32'(e_stall));
                chk("m_dat", 32'(m_dat_o), 32'(s_dat_i));
                if (e_scyc) begin
                    chk("s_we", 32'(s_we_o), 32'(m_we_i[owner]));
                    chk("s_adr", 32'(s_adr_o), 32'(m_adr_i[owner*AW +: AW]));
                    chk("s_dat", 32'(s_dat_o), 32'(m_dat_i[owner*DW +: DW]));
                end
            end
            @(posedge clk);
            if (!rst_n) begin
                owner = -1; last = NM - 1; outst = 0; waited = 0; mvalid = 1'b1;
            end else if (mvalid) begin
                if (owner < 0) begin
                    for (int k = 1; k <= NM; k++)
                        if (owner < 0 && cyc_s[(last + k) % NM]) owner = (last + k) % NM;
                end else if (drop) begin
                    last = owner; owner = -1; outst = 0; waited = 0;
                end else begin
                    waited = (outst > 0 && !ackf) ? waited + 1 : 0;
                    outst  = outst + int'(acc) - int'(ackf);
                    if (outst > MAXO || outst < 0) chk("outst_range", 32'(outst), 32'(MAXO));
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        m_cyc_i = '0; m_stb_i = '0; m_we_i = '0; m_adr_i = '0; m_dat_i = '0;
        s_ack_i = 0; s_stall_i = 0; s_dat_i = '0;
    endtask

    initial begin
        rst_n = 0;
        idle_inputs();
        repeat (3) step();
        rst_n = 1;
        #3;
        chk("rst_gnt", 32'(gnt_o), 32'h0);
        chk("rst_busy", 32'(busy_o), 32'h0);
        chk("rst_stall", 32'(m_stall_o), 32'h7);

        // Single read from master 0, acked two cycles after acceptance.
        step(); m_cyc_i[0] = 1; m_stb_i[0] = 1; m_adr_i[15:0] = 16'h0010;
        step(); #3; chk("t1_gnt", 32'(gnt_o), 32'h1);
        step(); m_stb_i[0] = 0;
        step(); s_ack_i = 1; s_dat_i = 16'hBEEF; #3;
        chk("t1_ack", 32'(m_ack_o), 32'h1);
        chk("t1_dat", 32'(m_dat_o), 32'hBEEF);
        step(); s_ack_i = 0; m_cyc_i[0] = 0; #3; chk("t1_noack", 32'(m_ack_o), 32'h0);
        step(); #3; chk("t1_idle", 32'(busy_o), 32'h0);

        // Simultaneous requests straight after reset.
        step(); rst_n = 0;
        step(); rst_n = 1; m_cyc_i = 3'b011;
        step(); #3; chk("t2_first", 32'(gnt_o), 32'h1);
        step(); m_cyc_i[0] = 0;
        step(); #3; chk("t2_gap", 32'(gnt_o), 32'h0);
        step(); #3; chk("t2_second", 32'(gnt_o), 32'h2);
        step(); m_cyc_i[1] = 0;
        step();

        // Six back-to-back strobes, acks 8 cycles after each accept.
        step(); m_cyc_i[0] = 1; m_stb_i[0] = 1;
        for (int n = 1; n <= 19; n++) begin
            step();
            m_stb_i[0] = (n <= 11);
            m_adr_i[15:0] = 16'h0100 + 16'(n);
            s_ack_i = (n inside {9, 10, 11, 12, 18, 19});
            #3;
            if (n == 4)  chk("t3_stall4", 32'(m_stall_o[0]), 32'h0);
            if (n == 5)  chk("t3_full", 32'(m_stall_o[0]), 32'h1);
            if (n == 9)  chk("t3_ack_full", 32'({m_stall_o[0], m_ack_o}), 32'h9);
            if (n == 10) chk("t3_release", 32'(m_stall_o[0]), 32'h0);
            if (n == 11) chk("t3_acc_ack", 32'(m_stall_o[0]), 32'h0);
        end
        step(); m_cyc_i[0] = 0; s_ack_i = 0;
        step();

        // Abort with two outstanding, then a late ack.
        step(); m_cyc_i[0] = 1; m_stb_i[0] = 1;
        step();
        step();
        step(); m_stb_i[0] = 0; m_cyc_i[0] = 0; m_cyc_i[1] = 1;
        step(); s_ack_i = 1; #3; chk("t4_late_ack", 32'(m_ack_o), 32'h0);
        step(); #3;
        chk("t4_gnt1", 32'(gnt_o), 32'h2);
        chk("t4_drop_ack", 32'(m_ack_o), 32'h0);
        step(); s_ack_i = 0; m_cyc_i[1] = 0;
        step();

        // Timeout with a slave that never acks.
        step(); m_cyc_i[0] = 1; m_stb_i[0] = 1;
        for (int n = 1; n <= 19; n++) begin
            step();
            if (n >= 2) m_stb_i[0] = 0;
            #3;
            if (n == 16) chk("t5_no_err", 32'(m_err_o), 32'h0);
            if (n == 17) chk("t5_err", 32'({s_cyc_o, m_err_o}), 32'h1);
            if (n == 18) chk("t5_idle", 32'({busy_o, gnt_o}), 32'h0);
            if (n == 19) chk("t5_regrant", 32'(gnt_o), 32'h1);
        end
        step(); m_cyc_i[0] = 0;
        step();

        // Reset in the middle of a cycle.
        step(); m_cyc_i[1] = 1; m_stb_i[1] = 1;
        step(); #3; chk("t6_gnt", 32'(gnt_o), 32'h2);
        step(); m_stb_i[1] = 0; s_ack_i = 1; rst_n = 0;
        step(); #3;
        chk("t6_rst_ctl", 32'({busy_o, s_cyc_o, gnt_o}), 32'h0);
        chk("t6_rst_m", 32'({m_ack_o, m_err_o, m_stall_o}), 32'h7);
        rst_n = 1; s_ack_i = 0;
        step(); m_cyc_i[1] = 0;
        step();

        // Random traffic.
        for (int c = 0; c < 4000; c++) begin
            step();
            rst_n = ($urandom_range(0, 399) != 0);
            for (int i = 0; i < NM; i++) begin
                if (!m_cyc_i[i]) m_cyc_i[i] = ($urandom_range(0, 3) == 0);
                else             m_cyc_i[i] = ($urandom_range(0, 15) != 0);
                m_stb_i[i] = m_cyc_i[i] & ($urandom_range(0, 1) == 1);
            end
            m_we_i    = NM'($urandom);
            m_adr_i   = (NM*AW)'({$urandom, $urandom});
            m_dat_i   = (NM*DW)'({$urandom, $urandom});
            s_stall_i = ($urandom_range(0, 3) == 0);
            s_ack_i   = ($urandom_range(0, 2) == 0);
            s_dat_i   = DW'($urandom);
        end
        step(); idle_inputs();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
